tq_dequant_4x4_pipe: RTL and testbench
======================================

TQ_DEQUANT_4X4_PIPE -- requirements
Module: tq_dequant_4x4_pipe

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 15, meaning signed quantized-level width.
REQ-002 SHALL have parameter OUT_WIDTH, default 16, meaning signed rescaled-coefficient width.
REQ-003 SHALL have one clock and an asynchronous, active-low reset: clk input 1 (rising-edge clock); rst_n input 1 (asynchronous reset, active low).
REQ-004 SHALL have the following data and control ports:
- qpmod6_i  input  3  (QP%6, sampled with row 0)
- qpdiv6_i  input  4  (QP/6, sampled with row 0)
- in_valid_i  input  1  (row beat valid)
- in_ready_o  output  1  (row beat accepted when high with in_valid_i)
- level0_i..level3_i  input  IN_WIDTH signed  (levels of the current row, columns 0..3)
- out_valid_o  output  1  (output row valid)
- out_ready_i  input  1  (downstream accepts output row)
- coeff0_o..coeff3_o  output  OUT_WIDTH signed  (rescaled coefficients)
- out_row_o  output  2  (row index 0..3 of the output beat)
- out_last_o  output  1  (high on row 3 beat)

Function
REQ-005 SHALL take a 4x4 block as 4 row beats, row 0 first, one row per accepted handshake.
REQ-006 SHALL keep an input row counter (0..3): +1 per accepted beat, wraps 3->0.
REQ-007 SHALL latch qpmod6_i/qpdiv6_i on the accepted row-0 beat; rows 1..3 SHALL use the latched values, and QP input changes mid-block SHALL be ignored.
REQ-008 SHALL use scale V by position class: class a = (even row, even col); class b = (odd row, odd col); class c = all others.
REQ-009 SHALL use V table (a,b,c) per qpmod6: 0:(10,16,13) 1:(11,18,14) 2:(13,20,16) 3:(14,23,18) 4:(16,25,20) 5:(18,29,23); qpmod6 6..7 SHALL give V=0 (all-zero outputs).
REQ-010 SHALL compute coeff = (level * V) << qpdiv6 in signed arithmetic at least IN_WIDTH+5+15 bits wide, with no rounding.
REQ-011 SHALL be a 2-stage pipeline: stage 1 registers the product, tag and QP shift; stage 2 registers shift/limit result, row index and last.
REQ-012 SHALL have the pipeline advance when (!out_valid_o || out_ready_i); in_ready_o SHALL equal that advance term.
REQ-013 SHALL, with no stall, present a row accepted in cycle N on outputs with out_valid_o high in cycle N+2.
REQ-014 SHALL, while out_valid_o is high and out_ready_i is low, hold all outputs stable and drop nothing; stage 1 SHALL also hold.
REQ-015 SHALL carry bubbles (in_valid_i low) as invalid stages, with out_valid_o low in the matching cycle.
REQ-016 SHALL sustain back-to-back blocks with no idle cycle between row 3 of one block and row 0 of the next.
REQ-017 SHALL drive out_row_o equal to the input row counter value of the beat, and out_last_o = (out_row_o == 3).

Reset
REQ-018 SHALL, on rst_n low, asynchronously clear: out_valid_o=0, coeff0_o..coeff3_o=0, out_row_o=0, out_last_o=0, row counter=0, latched QP=0, and all stage valids=0.
REQ-019 SHALL, when reset is asserted mid-block, discard the partial block; the first beat after reset release SHALL be row 0.
REQ-020 SHALL drive in_ready_o=1 during and after reset, since the pipeline is empty.

Configuration
REQ-021 SHALL, with macro TQ_DEQUANT_SAT_EN defined, saturate each coefficient to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
REQ-022 SHALL, without TQ_DEQUANT_SAT_EN, truncate each coefficient to its low OUT_WIDTH bits (two's-complement wrap).

Verification
REQ-023 SHALL cover: qp=0; block of all levels 1; out_ready_i high -> rows 0,2 = {10,13,10,13}; rows 1,3 = {13,16,13,16}; out_valid_o high 2 cycles after each beat; out_last_o high on row 3 only.
REQ-024 SHALL cover: qp=28 (mod 4, div 4), level(0,0)=2, level(1,1)=-3 -> coeff(0,0)=512, coeff(1,1)=-1200.
REQ-025 SHALL cover: qp=51 (mod 3, div 8), level(1,1)=16383, level(1,3)=-16384 -> with SAT_EN: 32767 and -32768; without SAT_EN: low 16 bits of 16383*23*256 and of -16384*23*256.
REQ-026 SHALL cover: out_ready_i held low 3 cycles while out_valid_o high -> in_ready_o low, outputs unchanged; on release, all 4 rows delivered in order with no loss or duplicates.
REQ-027 SHALL cover: qpmod6_i changed from 0 to 5 on row-2 beat -> rows 2,3 still scaled with qp 0; next block's row 0 uses qpmod6=5.
REQ-028 SHALL cover: rst_n pulsed low after row 1 accepted -> out_valid_o=0 at once; next accepted beat tagged out_row_o=0.

Source files
------------

// File: rtl/tq_dequant_4x4_pipe_if.sv
// ============================================================================
// tq_dequant_4x4_pipe_if : row-beat input stream and coefficient output stream
// Rev 1.0
// ============================================================================
`default_nettype none

interface tq_dequant_4x4_pipe_if #(
  parameter int IN_WIDTH  = 15,
  parameter int OUT_WIDTH = 16
);
  logic [2:0]                  qpmod6_i;
  logic [3:0]                  qpdiv6_i;
  logic                        in_valid_i;
  logic                        in_ready_o;
  logic signed [IN_WIDTH-1:0]  level0_i;
  logic signed [IN_WIDTH-1:0]  level1_i;
  logic signed [IN_WIDTH-1:0]  level2_i;
  logic signed [IN_WIDTH-1:0]  level3_i;
  logic                        out_valid_o;
  logic                        out_ready_i;
  logic signed [OUT_WIDTH-1:0] coeff0_o;
  logic signed [OUT_WIDTH-1:0] coeff1_o;
  logic signed [OUT_WIDTH-1:0] coeff2_o;
  logic signed [OUT_WIDTH-1:0] coeff3_o;
  logic [1:0]                  out_row_o;
  logic                        out_last_o;

  modport slave (
    input  qpmod6_i, qpdiv6_i, in_valid_i, level0_i, level1_i, level2_i, level3_i, out_ready_i,
    output in_ready_o, out_valid_o, coeff0_o, coeff1_o, coeff2_o, coeff3_o, out_row_o, out_last_o
  );

  modport master (
    output qpmod6_i, qpdiv6_i, in_valid_i, level0_i, level1_i, level2_i, level3_i, out_ready_i,
    input  in_ready_o, out_valid_o, coeff0_o, coeff1_o, coeff2_o, coeff3_o, out_row_o, out_last_o
  );
endinterface

`default_nettype wire

// File: rtl/tq_dequant_4x4_pipe.sv
// ============================================================================
// tq_dequant_4x4_pipe : 4x4 block dequantiser, (level*V)<<qpdiv6, 2-stage pipe
// Build option: define TQ_DEQUANT_SAT_EN to saturate instead of wrapping.
// Rev 1.0
// ============================================================================
`default_nettype none

module tq_dequant_4x4_pipe #(
  parameter int IN_WIDTH  = 15,
  parameter int OUT_WIDTH = 16
) (
  input wire clk,
  input wire rst_n,
  tq_dequant_4x4_pipe_if.slave bus
);

  localparam int PROD_W = IN_WIDTH + 6;
  localparam int WIDE_W = PROD_W + 15;

  localparam logic [1:0] CLS_A = 2'd0;
  localparam logic [1:0] CLS_B = 2'd1;
  localparam logic [1:0] CLS_C = 2'd2;

  function automatic logic [4:0] f_vscale(input logic [2:0] qpm, input logic [1:0] cls);
    logic [4:0] v;
    v = '0;
    case (qpm)
      3'd0:    v = (cls == CLS_A) ? 5'd10 : (cls == CLS_B) ? 5'd16 : 5'd13;
      3'd1:    v = (cls == CLS_A) ? 5'd11 : (cls == CLS_B) ? 5'd18 : 5'd14;
      3'd2:    v = (cls == CLS_A) ? 5'd13 : (cls == CLS_B) ? 5'd20 : 5'd16;
      3'd3:    v = (cls == CLS_A) ? 5'd14 : (cls == CLS_B) ? 5'd23 : 5'd18;
      3'd4:    v = (cls == CLS_A) ? 5'd16 : (cls == CLS_B) ? 5'd25 : 5'd20;
      3'd5:    v = (cls == CLS_A) ? 5'd18 : (cls == CLS_B) ? 5'd29 : 5'd23;
      default: v = '0;
    endcase
    return v;
  endfunction

  logic signed [IN_WIDTH-1:0]  w_level [4];
  logic signed [PROD_W-1:0]    w_prod  [4];
  logic signed [OUT_WIDTH-1:0] coeff_d [4];
  logic                        w_adv;
  logic                        w_acc;
  logic [2:0]                  w_qpm;
  logic [3:0]                  w_qpd;

  logic [1:0]                  row_q;
  logic [1:0]                  row_d;
  logic [2:0]                  qpm_q;
  logic [3:0]                  qpd_q;

  logic                        s1_valid_q;
  logic signed [PROD_W-1:0]    s1_prod_q [4];
  logic [3:0]                  s1_shift_q;
  logic [1:0]                  s1_row_q;

  logic                        out_valid_q;
  logic signed [OUT_WIDTH-1:0] coeff_q [4];
  logic [1:0]                  out_row_q;
  logic                        out_last_q;

  assign w_level[0] = bus.level0_i;
  assign w_level[1] = bus.level1_i;
  assign w_level[2] = bus.level2_i;
  assign w_level[3] = bus.level3_i;

  // Both stages move together; a full output stage blocks everything behind it.
  assign w_adv = !out_valid_q || bus.out_ready_i;
  assign w_acc = bus.in_valid_i && w_adv;
  assign row_d = row_q + 2'd1;

  // Row 0 takes QP straight from the inputs; later rows use the block's latched QP.
  assign w_qpm = (row_q == 2'd0) ? bus.qpmod6_i : qpm_q;
  assign w_qpd = (row_q == 2'd0) ? bus.qpdiv6_i : qpd_q;

  generate
    for (genvar c = 0; c < 4; c++) begin : g_col
      localparam logic COL_ODD = 1'(c % 2);
      logic [1:0]               w_cls;
      logic signed [WIDE_W-1:0] w_wide;

      assign w_cls   = (row_q[0] != COL_ODD) ? CLS_C : (COL_ODD ? CLS_B : CLS_A);
      assign w_prod[c] = PROD_W'(w_level[c]) * PROD_W'($signed({1'b0, f_vscale(w_qpm, w_cls)}));
      assign w_wide  = WIDE_W'(s1_prod_q[c]) <<< s1_shift_q;

`ifdef TQ_DEQUANT_SAT_EN
      logic [WIDE_W-OUT_WIDTH:0] w_hi;
      assign w_hi = w_wide[WIDE_W-1:OUT_WIDTH-1];
      assign coeff_d[c] = ((&w_hi) || !(|w_hi)) ? w_wide[OUT_WIDTH-1:0] :
                          (w_wide[WIDE_W-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                            : {1'b0, {(OUT_WIDTH-1){1'b1}}});
`else
      logic w_unused_hi;
      assign w_unused_hi = ^w_wide[WIDE_W-1:OUT_WIDTH];
      assign coeff_d[c]  = w_wide[OUT_WIDTH-1:0];
`endif
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q       <= '0;
      qpm_q       <= '0;
      qpd_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_shift_q  <= '0;
      s1_row_q    <= '0;
      out_valid_q <= 1'b0;
      out_row_q   <= '0;
      out_last_q  <= 1'b0;
      for (int c = 0; c < 4; c++) begin
        s1_prod_q[c] <= '0;
        coeff_q[c]   <= '0;
      end
    end else begin
      if (w_acc) begin
        row_q <= row_d;
        if (row_q == 2'd0) begin
          qpm_q <= bus.qpmod6_i;
          qpd_q <= bus.qpdiv6_i;
        end
      end
      if (w_adv) begin
        s1_valid_q <= bus.in_valid_i;
        if (bus.in_valid_i) begin
          s1_prod_q  <= w_prod;
          s1_shift_q <= w_qpd;
          s1_row_q   <= row_q;
        end
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          coeff_q    <= coeff_d;
          out_row_q  <= s1_row_q;
          out_last_q <= (s1_row_q == 2'd3);
        end
      end
    end
  end

  assign bus.in_ready_o  = w_adv;
  assign bus.out_valid_o = out_valid_q;
  assign bus.coeff0_o    = coeff_q[0];
  assign bus.coeff1_o    = coeff_q[1];
  assign bus.coeff2_o    = coeff_q[2];
  assign bus.coeff3_o    = coeff_q[3];
  assign bus.out_row_o   = out_row_q;
  assign bus.out_last_o  = out_last_q;

endmodule

`default_nettype wire

// File: tb/tb_tq_dequant_4x4_pipe.sv
// ============================================================================
// tb_tq_dequant_4x4_pipe : vector table, directed corner sequences, random run
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_tq_dequant_4x4_pipe;

  localparam int IW = 15;
  localparam int OW = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  tq_dequant_4x4_pipe_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) bus ();

  tq_dequant_4x4_pipe #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int qpm;
    int qpd;
    int lv[4];
    int ex[4];
  } vec_t;

  typedef struct {
    int c[4];
    int row;
    int last;
    int cyc;
  } exp_t;

  int VT[6][3] = '{'{10,16,13}, '{11,18,14}, '{13,20,16},
                   '{14,23,18}, '{16,25,20}, '{18,29,23}};

  vec_t tbl[$];
  exp_t sbq[$];
  int   n_cmp   = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   m_row   = 0;
  int   m_qpm   = 0;
  int   m_qpd   = 0;
  bit   lat_chk = 1'b0;
  bit   rnd_rdy = 1'b0;
  int   zero4[4] = '{0, 0, 0, 0};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Spec-level reference: V by position class and QP%6, times 2^(QP/6), then fit.
  function automatic int ref_coeff(int lvl, int r, int c, int qm, int qd);
    longint p;
    int v;
    int cls;
    logic signed [15:0] t;
    if (r % 2 == 0 && c % 2 == 0)      cls = 0;
    else if (r % 2 == 1 && c % 2 == 1) cls = 1;
    else                               cls = 2;
    v = (qm <= 5) ? VT[qm][cls] : 0;
    p = longint'(lvl) * longint'(v) * (longint'(1) << qd);
`ifdef TQ_DEQUANT_SAT_EN
    if (p > 32767)       p = 32767;
    else if (p < -32768) p = -32768;
`endif
    t = p[15:0];
    return int'(t);
  endfunction

  function automatic int outc(int i);
    case (i)
      0:       return int'(bus.coeff0_o);
      1:       return int'(bus.coeff1_o);
      2:       return int'(bus.coeff2_o);
      default: return int'(bus.coeff3_o);
    endcase
  endfunction

  task automatic add_row(input int qm, input int qd, input int l[4], input int x[4]);
    vec_t v;
    v.qpm = qm; v.qpd = qd; v.lv = l; v.ex = x;
    tbl.push_back(v);
  endtask

  task automatic drive_row(input int qpm, input int qpd, input int lv[4],
                           input bit use_tbl, input int tex[4]);
    exp_t e;
    bit   got;
    @(posedge clk); #1;
    bus.qpmod6_i   = 3'(qpm);
    bus.qpdiv6_i   = 4'(qpd);
    bus.level0_i   = IW'(lv[0]);
    bus.level1_i   = IW'(lv[1]);
    bus.level2_i   = IW'(lv[2]);
    bus.level3_i   = IW'(lv[3]);
    bus.in_valid_i = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      got = bus.in_ready_o;
    end
    if (!got) begin
      check("accept_timeout", 0, 1);
    end else begin
      if (m_row == 0) begin m_qpm = qpm; m_qpd = qpd; end
      e.row  = m_row;
      e.last = (m_row == 3) ? 1 : 0;
      e.cyc  = cyc;
      for (int c = 0; c < 4; c++)
        e.c[c] = use_tbl ? tex[c] : ref_coeff(lv[c], m_row, c, m_qpm, m_qpd);
      sbq.push_back(e);
      m_row = (m_row + 1) % 4;
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
  endtask

  task automatic drain(input string nm);
    for (int k = 0; k < 200 && sbq.size() != 0; k++) @(negedge clk);
    check(nm, sbq.size(), 0);
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rnd_rdy) bus.out_ready_i = ($urandom_range(0, 3) != 0);
    end
  end

  // Scoreboard: every consumed output beat must match the oldest outstanding row.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid_o && bus.out_ready_i) begin
        if (sbq.size() == 0) begin
          check("unexpected_beat", 1, 0);
        end else begin
          e = sbq.pop_front();
          for (int c = 0; c < 4; c++) check($sformatf("coeff%0d_row%0d", c, e.row), outc(c), e.c[c]);
          check("out_row", bus.out_row_o, e.row);
          check("out_last", bus.out_last_o, e.last);
          if (lat_chk) check("latency", cyc - e.cyc, 2);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lv[4];
    bus.qpmod6_i = '0; bus.qpdiv6_i = '0; bus.in_valid_i = 1'b0; bus.out_ready_i = 1'b1;
    bus.level0_i = '0; bus.level1_i = '0; bus.level2_i = '0; bus.level3_i = '0;

    // Vector table: qp=0 all ones, qp=28, qp=51 extremes, mid-block QP change, qp%6>5
    add_row(0, 0, '{1,1,1,1}, '{10,13,10,13});
    add_row(0, 0, '{1,1,1,1}, '{13,16,13,16});
    add_row(0, 0, '{1,1,1,1}, '{10,13,10,13});
    add_row(0, 0, '{1,1,1,1}, '{13,16,13,16});
    add_row(4, 4, '{2,0,0,0},  '{512,0,0,0});
    add_row(4, 4, '{0,-3,0,0}, '{0,-1200,0,0});
    add_row(4, 4, '{0,-5,0,0}, '{0,-1600,0,0});
    add_row(4, 4, '{0,0,0,7},  '{0,0,0,2800});
    add_row(3, 8, '{0,0,0,0},  '{0,0,0,0});
`ifdef TQ_DEQUANT_SAT_EN
    add_row(3, 8, '{0,16383,0,-16384}, '{0,32767,0,-32768});
`else
    add_row(3, 8, '{0,16383,0,-16384}, '{0,-5888,0,0});
`endif
    add_row(3, 8, '{1,0,0,0},  '{3584,0,0,0});
    add_row(3, 8, '{0,0,-1,0}, '{0,0,-4608,0});
    add_row(0, 0, '{1,1,1,1}, '{10,13,10,13});
    add_row(0, 0, '{1,1,1,1}, '{13,16,13,16});
    add_row(5, 0, '{1,1,1,1}, '{10,13,10,13});
    add_row(5, 0, '{1,1,1,1}, '{13,16,13,16});
    add_row(5, 0, '{1,1,1,1}, '{18,23,18,23});
    add_row(5, 0, '{1,1,1,1}, '{23,29,23,29});
    add_row(5, 0, '{1,1,1,1}, '{18,23,18,23});
    add_row(5, 0, '{1,1,1,1}, '{23,29,23,29});
    add_row(6, 3, '{1234,-77,5,16000}, '{0,0,0,0});
    add_row(2, 3, '{1234,-77,5,16000}, '{0,0,0,0});
    add_row(6, 3, '{1234,-77,5,16000}, '{0,0,0,0});
    add_row(6, 3, '{1234,-77,5,16000}, '{0,0,0,0});

    // Reset state
    #1 rst_n = 1'b0;
    #2;
    check("rst_out_valid", bus.out_valid_o, 0);
    check("rst_out_row", bus.out_row_o, 0);
    check("rst_out_last", bus.out_last_o, 0);
    for (int c = 0; c < 4; c++) check("rst_coeff", outc(c), 0);
    check("rst_in_ready", bus.in_ready_o, 1);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", bus.in_ready_o, 1);

    // Table run: back-to-back blocks, ready always high, fixed 2-cycle latency
    lat_chk = 1'b1;
    foreach (tbl[i]) drive_row(tbl[i].qpm, tbl[i].qpd, tbl[i].lv, 1'b1, tbl[i].ex);
    idle();
    drain("drain_table");
    lat_chk = 1'b0;

    // Stall with a valid output held for 3 cycles, then release
    @(posedge clk); #1 bus.out_ready_i = 1'b0;
    fork
      begin
        int sl[4];
        for (int r = 0; r < 4; r++) begin
          for (int c = 0; c < 4; c++) sl[c] = int'($urandom_range(0, 2000)) - 1000;
          drive_row(2, 1, sl, 1'b0, zero4);
        end
        idle();
      end
      begin
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
          @(negedge clk);
          seen = bus.out_valid_o;
        end
        check("stall_valid_seen", seen, 1);
        for (int s = 0; s < 3; s++) begin
          check("stall_in_ready", bus.in_ready_o, 0);
          check("stall_out_valid", bus.out_valid_o, 1);
          if (sbq.size() == 0) begin
            check("stall_queue_empty", 0, 1);
          end else begin
            check("stall_hold_row", bus.out_row_o, sbq[0].row);
            for (int c = 0; c < 4; c++) check("stall_hold_coeff", outc(c), sbq[0].c[c]);
          end
          @(negedge clk);
        end
        @(posedge clk); #1 bus.out_ready_i = 1'b1;
      end
    join
    drain("drain_stall");

    // Reset after row 1 accepted: partial block discarded, restart at row 0
    for (int c = 0; c < 4; c++) lv[c] = 100 + c;
    drive_row(1, 1, lv, 1'b0, zero4);
    drive_row(1, 1, lv, 1'b0, zero4);
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", bus.out_valid_o, 0);
    check("midrst_out_row", bus.out_row_o, 0);
    check("midrst_coeff0", outc(0), 0);
    check("midrst_in_ready", bus.in_ready_o, 1);
    sbq.delete();
    m_row = 0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) lv[c] = 3 * r - c;
      drive_row(3, 2, lv, 1'b0, zero4);
    end
    idle();
    drain("drain_reset");

    // Random traffic with bubbles and random back-pressure
    rnd_rdy = 1'b1;
    for (int b = 0; b < 80; b++) begin
      if ($urandom_range(0, 3) == 0) idle();
      for (int c = 0; c < 4; c++) begin
        case ($urandom_range(0, 5))
          0:       lv[c] = 16383;
          1:       lv[c] = -16384;
          default: lv[c] = int'($urandom_range(0, 32767)) - 16384;
        endcase
      end
      drive_row(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)), lv, 1'b0, zero4);
    end
    idle();
    rnd_rdy = 1'b0;
    @(posedge clk); #1 bus.out_ready_i = 1'b1;
    drain("drain_random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
